// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and helpers for the fetch-stage program counter.
// Holds the legacy control encodings (reset/chip-enable/stall/branch levels),
// the default instruction address width and reset vector, and a helper that
// turns the sequential step into the number of alignment bits.
package pc_gen_pkg;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic NO_STOP      = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic BRANCH       = 1'b1;

  localparam int unsigned INST_ADDR_W  = 32;
  localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;

  // log2 of a power-of-two step (1 -> 0, 2 -> 1, 4 -> 2, 8 -> 3)
  function automatic int unsigned align_bits(input int unsigned step);
    int unsigned n;
    n = 0;
    for (int unsigned i = 1; i < step; i = i * 2) begin
      n = n + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/pc_redirect_buf.sv
// pc_redirect_buf: one-entry buffer for a branch target that arrives while
// fetch is stalled.
// Ports:
//   clk, rst   - clock, asynchronous active-high reset
//   capture    - load target_in if the entry is empty (a full entry is kept)
//   consume    - entry has been applied to the pc; empty it
//   clear      - flush; empty it
//   target_in  - branch target to capture
//   valid      - entry holds a target
//   target     - buffered target
module pc_redirect_buf #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              consume,
  input  logic              clear,
  input  logic [ADDR_W-1:0] target_in,
  output logic              valid,
  output logic [ADDR_W-1:0] target
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (clear || consume) begin
      valid  <= 1'b0;
      target <= '0;
    end else if (capture && !valid) begin
      valid  <= 1'b1;
      target <= target_in;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: fetch-stage program counter with chip enable, flush/stall/branch
// redirection and a one-entry buffer so a branch seen during a stall is
// applied once the stall lifts.
// Optional feature macro: PC_MISALIGN_CHK_EN (registered misalignment flag;
// when undefined misalign_o is tied 0).
// Ports:
//   clk, rst                - clock, asynchronous active-high reset
//   stall[STALL_W-1:0]      - stall vector, only bit 0 freezes the pc
//   flush, new_pc           - highest-priority redirect and its target
//   branch_flag_i           - taken branch from decode
//   branch_target_address_i - branch target
//   pc, ce                  - fetch address and instruction memory enable
//   redirect_pending_o      - a buffered branch target is waiting
//   misalign_o              - pc is not STEP-aligned
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned ADDR_W    = INST_ADDR_W,
  parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
  parameter int unsigned STEP      = 4,
  parameter int unsigned STALL_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  input  logic [ADDR_W-1:0]  new_pc,
  input  logic               branch_flag_i,
  input  logic [ADDR_W-1:0]  branch_target_address_i,
  output logic [ADDR_W-1:0]  pc,
  output logic               ce,
  output logic               redirect_pending_o,
  output logic               misalign_o
);

  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_VEC);
  localparam logic [ADDR_W-1:0] STEP_INC = ADDR_W'(STEP);

  logic              stop;
  logic              taken;
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_target;
  logic              buf_capture;
  logic              buf_consume;
  logic              buf_clear;
  logic [ADDR_W-1:0] pc_next;

  logic unused_stall;
  assign unused_stall = ^stall[STALL_W-1:1];

  assign stop  = (stall[0] == STOP);
  assign taken = (branch_flag_i == BRANCH);

  // A live branch on an unstalled cycle also empties the buffer: the
  // buffered target is older and has been superseded.
  assign buf_clear   = (ce == CHIP_ENABLE) && flush;
  assign buf_capture = (ce == CHIP_ENABLE) && !flush && stop && taken;
  assign buf_consume = (ce == CHIP_ENABLE) && !flush && !stop && (taken || buf_valid);

  pc_redirect_buf #(
    .ADDR_W (ADDR_W)
  ) u_redirect_buf (
    .clk       (clk),
    .rst       (rst),
    .capture   (buf_capture),
    .consume   (buf_consume),
    .clear     (buf_clear),
    .target_in (branch_target_address_i),
    .valid     (buf_valid),
    .target    (buf_target)
  );

  assign redirect_pending_o = buf_valid;

  always_comb begin
    pc_next = pc + STEP_INC;
    if (ce == CHIP_DISABLE) begin
      pc_next = RST_PC;
    end else if (flush) begin
      pc_next = new_pc;
    end else if (stop) begin
      pc_next = pc;
    end else if (taken) begin
      pc_next = branch_target_address_i;
    end else if (buf_valid) begin
      pc_next = buf_target;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      ce <= CHIP_DISABLE;
    end else begin
      ce <= CHIP_ENABLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      pc <= RST_PC;
    end else begin
      pc <= pc_next;
    end
  end

`ifdef PC_MISALIGN_CHK_EN
  // Tracks the low bits of whatever pc is loaded; sequential steps keep them,
  // so the flag persists until an aligned target is loaded.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << align_bits(STEP)) - 1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      misalign_o <= 1'b0;
    end else begin
      misalign_o <= |(pc_next & ALIGN_MASK);
    end
  end
`else
  assign misalign_o = 1'b0;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: randomized and directed checks of pc_gen against a queue-based
// reference model of the fetch address rules.
module tb_pc_gen;

  localparam int unsigned AW = 16;

  logic          clk;
  logic          rst;
  logic [5:0]    stall;
  logic          flush;
  logic [AW-1:0] new_pc;
  logic          branch_flag_i;
  logic [AW-1:0] branch_target_address_i;
  logic [AW-1:0] pc;
  logic          ce;
  logic          redirect_pending_o;
  logic          misalign_o;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [AW-1:0] m_pc;
  logic          m_ce;
  logic [AW-1:0] m_buf[$];

  pc_gen #(
    .ADDR_W    (AW),
    .RESET_VEC (32'h0000_0000),
    .STEP      (4),
    .STALL_W   (6)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .stall                   (stall),
    .flush                   (flush),
    .new_pc                  (new_pc),
    .branch_flag_i           (branch_flag_i),
    .branch_target_address_i (branch_target_address_i),
    .pc                      (pc),
    .ce                      (ce),
    .redirect_pending_o      (redirect_pending_o),
    .misalign_o              (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic exp_misalign();
`ifdef PC_MISALIGN_CHK_EN
    return (m_pc % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_pc = '0;
    m_ce = 1'b0;
    m_buf.delete();
  endtask

  task automatic compare_all();
    check("pc", 32'(pc), 32'(m_pc));
    check("ce", 32'(ce), 32'(m_ce));
    check("pending", 32'(redirect_pending_o), 32'(m_buf.size() != 0));
    check("misalign", 32'(misalign_o), 32'(exp_misalign()));
  endtask

  // Advance the model by one edge from the current inputs, then clock the DUT
  // and compare just after the edge.
  task automatic cycle();
    if (rst) begin
      model_reset();
    end else if (!m_ce) begin
      m_ce = 1'b1;
      m_pc = '0;
    end else if (flush) begin
      m_pc = new_pc;
      m_buf.delete();
    end else if (stall[0]) begin
      if (branch_flag_i && m_buf.size() == 0) m_buf.push_back(branch_target_address_i);
    end else if (branch_flag_i) begin
      m_pc = branch_target_address_i;
      m_buf.delete();
    end else if (m_buf.size() != 0) begin
      m_pc = m_buf.pop_front();
    end else begin
      m_pc = m_pc + AW'(4);
    end
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle_inputs();
    stall = '0;
    flush = 1'b0;
    new_pc = '0;
    branch_flag_i = 1'b0;
    branch_target_address_i = '0;
  endtask

  initial begin
    logic [31:0] r;
    idle_inputs();
    rst = 1'b1;
    model_reset();
    #1;
    compare_all();

    // reset release
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("rel_pc0", 32'(pc), 32'h0);
    check("rel_ce", 32'(ce), 32'h1);
    cycle();
    check("rel_pc4", 32'(pc), 32'h4);
    cycle();
    check("rel_pc8", 32'(pc), 32'h8);
    cycle();
    cycle();
    check("at_10", 32'(pc), 32'h10);

    // branch, not stalled
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0200;
    cycle();
    check("br_200", 32'(pc), 32'h200);
    idle_inputs();
    cycle();
    check("br_204", 32'(pc), 32'h204);

    // branch during stall
    flush = 1'b1;
    new_pc = 16'h0040;
    cycle();
    idle_inputs();
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0800;
    cycle();
    check("stall_hold", 32'(pc), 32'h40);
    check("stall_pend", 32'(redirect_pending_o), 32'h1);
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0900;
    cycle();
    branch_flag_i = 1'b0;
    cycle();
    check("stall_hold3", 32'(pc), 32'h40);
    stall = 6'b111110;
    cycle();
    check("buf_apply", 32'(pc), 32'h800);
    check("buf_empty", 32'(redirect_pending_o), 32'h0);

    // flush precedence over stall, branch and a pending entry
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0800;
    cycle();
    check("fl_pend", 32'(redirect_pending_o), 32'h1);
    flush = 1'b1;
    new_pc = 16'h0180;
    branch_target_address_i = 16'h0300;
    cycle();
    check("fl_pc", 32'(pc), 32'h180);
    check("fl_clr", 32'(redirect_pending_o), 32'h0);
    idle_inputs();
    cycle();
    check("fl_seq", 32'(pc), 32'h184);

    // wrap at the top of the address space
    flush = 1'b1;
    new_pc = 16'hFFFC;
    cycle();
    idle_inputs();
    cycle();
    check("wrap", 32'(pc), 32'h0);

    // asynchronous reset with a buffered target
    stall = 6'b000001;
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0500;
    cycle();
    idle_inputs();
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("arst_pc", 32'(pc), 32'h0);
    check("arst_ce", 32'(ce), 32'h0);
    check("arst_pend", 32'(redirect_pending_o), 32'h0);
    cycle();
    rst = 1'b0;
    cycle();
    cycle();

    // misaligned targets
    branch_flag_i = 1'b1;
    branch_target_address_i = 16'h0202;
    cycle();
    check("mis_pc", 32'(pc), 32'h202);
    idle_inputs();
    cycle();
    check("mis_seq", 32'(pc), 32'h206);
    flush = 1'b1;
    new_pc = 16'h0300;
    cycle();
    idle_inputs();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom();
      stall = 6'(r >> 8);
      stall[0] = (r % 3) == 0;
      branch_flag_i = ((r >> 16) % 4) == 0;
      flush = ((r >> 20) % 16) == 0;
      r = $urandom();
      branch_target_address_i = AW'(r);
      new_pc = AW'(r >> 16);
      if (((r >> 2) % 8) != 0) begin
        branch_target_address_i = branch_target_address_i & 16'hFFFC;
        new_pc = new_pc & 16'hFFFC;
      end
      rst = ($urandom() % 100) == 0;
      cycle();
    end
    rst = 1'b0;
    idle_inputs();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
